// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB initiator
// Purpose: FSM state enum, APB4 pprot bit positions, default bus widths.
// Ports: none (package).
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // APB4 pprot bit positions
  localparam int PPROT_PRIV   = 0;
  localparam int PPROT_NONSEC = 1;
  localparam int PPROT_INSTR  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_initiator_if.sv
// rtl/apb_initiator_if.sv - APB4 bus bundle between initiator and fabric
// Purpose: groups the APB4 request and completion signals.
// Modports: master drives paddr/psel/penable/pprot/pwrite/pwdata/pstrb and
//           receives pready/prdata/pslverr; slave is the mirror image.
interface apb_initiator_if import apb_pkg::*; #(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic [2:0]          pprot;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic                pready;
  logic [DATA_W-1:0]   prdata;
  logic                pslverr;

  modport master (
    output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - saturating wait counter for ACCESS timeout
// Purpose: counts enabled cycles since the last clear, saturating at LIMIT.
// Ports: clock, reset (async active-low), clr (restart at 0), en (count this
//        cycle), expired (an enabled cycle now reaches LIMIT).
module apb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAX  = CW'(LIMIT);
  localparam logic [CW-1:0] LAST = (LIMIT < 1) ? '0 : CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Asserted in the cycle whose increment would bring the count to LIMIT,
  // so the transfer ends after exactly LIMIT unanswered ACCESS cycles.
  assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - valid/ready request port to APB4 initiator bridge
// Purpose: runs one APB4 transfer per request (SETUP then ACCESS) and returns
//          read data and error status on a valid/ready response port.
// Ports: clock, reset (async active-low); req_valid/req_ready with
//        req_addr/req_write/req_wdata/req_wstrb/req_prot; rsp_valid/rsp_ready
//        with rsp_rdata/rsp_err; apb (apb_initiator_if.master bus bundle).
// Macro: APB_INITIATOR_TIMEOUT_EN ends an ACCESS after TIMEOUT cycles
//        without pready, reporting rsp_err=1 and rsp_rdata=0.
module apb_initiator import apb_pkg::*; #(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_write,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [2:0]          req_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  apb_initiator_if.master     apb
);

  apb_state_e state, state_nxt;
  logic       timeout_hit;

`ifdef APB_INITIATOR_TIMEOUT_EN
  logic cnt_clr, cnt_en, cnt_expired;

  // SETUP always precedes ACCESS, so clearing there restarts each transfer.
  assign cnt_clr = (state == SETUP);
  assign cnt_en  = (state == ACCESS) && !apb.pready;

  apb_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout_cnt (
    .clock   (clock),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  // cnt_en already excludes pready, so a late pready wins over the timeout.
  assign timeout_hit = cnt_expired;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SETUP;
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (apb.pready || timeout_hit) state_nxt = RESP;
      RESP:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus and response registers. Address/data fields only load on accept, so
  // they stay stable across SETUP/ACCESS and keep their values afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      apb.paddr   <= '0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pprot   <= '0;
      apb.pwrite  <= 1'b0;
      apb.pwdata  <= '0;
      apb.pstrb   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            apb.paddr   <= req_addr;
            apb.pwrite  <= req_write;
            apb.pwdata  <= req_wdata;
            apb.pprot   <= req_prot;
            apb.pstrb   <= req_write ? req_wstrb : '0;
            apb.psel    <= 1'b1;
            apb.penable <= 1'b0;
          end
        end
        SETUP: apb.penable <= 1'b1;
        ACCESS: begin
          if (apb.pready) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= apb.pwrite ? '0 : apb.prdata;
            rsp_err     <= apb.pslverr;
          end else if (timeout_hit) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/apb_initiator.md
# apb_initiator

Converts a single-outstanding valid/ready request/response port into APB4 transfers. It sits between the core's memory-mapped peripheral path and the APB fabric: it drives the bus side that the APB delayer and responders receive, and it collects each transfer's read data and error status. It performs one transfer at a time through an explicit SETUP/ACCESS sequence. An optional timeout terminates transfers to a responder that never answers.

## Interface
- ADDR_W, 32, address width (paddr, req_addr)
- DATA_W, 32, data width; pstrb width is DATA_W/8
- TIMEOUT, 255, maximum ACCESS cycles without pready; used only with APB_INITIATOR_TIMEOUT_EN

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_addr  in  ADDR_W  byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  write byte strobes
- req_prot  in  3  protection attributes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  slave error or timeout
- paddr, psel, penable, pprot, pwrite, pwdata, pstrb  out  APB4 initiator signals
- pready, prdata, pslverr  in  APB4 responder signals

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - req_ready=1.
  - On req_valid: latch addr/write/wdata/prot into registers; latch wstrb for writes and force it to 0 for reads.
  - Go to SETUP.
- SETUP
  - psel=1, penable=0.
  - Unconditionally go to ACCESS next cycle.
- ACCESS
  - psel=1, penable=1.
  - paddr, pwrite, pwdata, pstrb and pprot hold stable from SETUP through the end of ACCESS.
  - On pready=1: latch prdata (reads) or 0 (writes) into rsp_rdata, latch pslverr into rsp_err, go to RESP.
- RESP
  - rsp_valid=1.
  - rsp_rdata and rsp_err hold stable until rsp_ready=1, then go to IDLE.
- req_ready is high only in IDLE. No request is accepted while a transfer or response is pending.
- psel and penable are 0 in IDLE and RESP.
- Bus-side outputs are registered. They retain their last values outside transfers, except psel and penable.
- req_valid arriving during RESP waits. It is accepted in the IDLE cycle after the response handshake.
- Reset asserted mid-transfer aborts it:
  - psel and penable fall asynchronously.
  - No response is produced.
  - State returns to IDLE.

## Timing
- Every output resets to 0, with one exception: req_ready reads 1 once reset deasserts, because the state is IDLE.
- Example with a zero-wait responder (pready high in the first ACCESS cycle):
  - Request accepted at edge 0.
  - SETUP during cycle 1, ACCESS during cycle 2.
  - rsp_valid high in cycle 3.
  - Accept-to-response latency is 3 cycles.
- Each low-pready ACCESS cycle adds 1 cycle of latency.
- With rsp_ready held high, back-to-back requests complete one every 4 cycles.
- rsp_valid never depends combinationally on rsp_ready. req_ready never depends combinationally on req_valid.

## Configuration
- APB_INITIATOR_TIMEOUT_EN defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT while pready is still 0, the transfer terminates: psel and penable drop next cycle, state goes to RESP, rsp_err=1, rsp_rdata=0.
  - pready=1 in the same cycle the count reaches TIMEOUT wins: normal completion.
- Undefined:
  - No counter.
  - ACCESS waits indefinitely for pready.
  - TIMEOUT is ignored.

## Structure
- Shared package apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP),
  - the APB4 pprot bit-position constants,
  - the default ADDR_W/DATA_W.
- Natural sub-module: apb_timeout_cnt, a saturating counter with clear and enable that outputs an expired flag. It is instantiated only under APB_INITIATOR_TIMEOUT_EN.

## Test plan
- Zero-wait read:
  - Stimulus: req addr 0x1000_0004; responder prdata 0xDEAD_BEEF, pready in the first ACCESS cycle.
  - Required: one SETUP and one ACCESS cycle; rsp_valid 3 cycles after accept; rsp_rdata 0xDEAD_BEEF, rsp_err 0.
- Write with waits:
  - Stimulus: wdata 0x1234_5678, wstrb 0x3; pready low for 4 ACCESS cycles.
  - Required: paddr/pwdata/pstrb stable throughout; rsp_valid 7 cycles after accept; rsp_rdata 0.
- Slave error:
  - Stimulus: pslverr=1 with pready.
  - Required: rsp_err 1 held until rsp_ready.
- Response backpressure:
  - Stimulus: rsp_ready low 5 cycles; second req_valid waiting.
  - Required: req_ready stays 0; second transfer's SETUP starts 2 cycles after the rsp handshake.
- Timeout (macro on, TIMEOUT=8):
  - Stimulus: pready never asserts.
  - Required: psel drops after 8 ACCESS cycles; rsp_err 1, rsp_rdata 0.
  - Same run with the macro off: psel stays high indefinitely.
- Reset mid-ACCESS:
  - Stimulus: reset asserted during ACCESS.
  - Required: psel/penable 0 immediately; no rsp_valid; req_ready 1 after reset deasserts.
